// File: rtl/apb_pkg.sv
// Shared types for the round-robin APB master: FSM states, default bus widths and the request record.
package apb_pkg;

    localparam int APB_DATA_WIDTH = 32;
    localparam int APB_ADDR_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    typedef struct packed {
        logic                      write;
        logic [APB_ADDR_WIDTH-1:0] addr;
        logic [APB_DATA_WIDTH-1:0] wdata;
    } apb_req_t;

endpackage

// File: rtl/apb_rr_master_if.sv
// Requester-side valid/ready/response bundle plus the APB completer bus of apb_rr_master.
interface apb_rr_master_if #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = apb_pkg::APB_DATA_WIDTH,
    parameter int ADDR_WIDTH = apb_pkg::APB_ADDR_WIDTH
);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_write;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_rdata;
    logic                          rsp_err;

    logic                          PSEL;
    logic                          PENABLE;
    logic                          PWRITE;
    logic [ADDR_WIDTH-1:0]         PADDR;
    logic [DATA_WIDTH-1:0]         PWDATA;
    logic [DATA_WIDTH-1:0]         PRDATA;
    logic                          PREADY;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

endinterface

// File: rtl/apb_rr_master_arbiter.sv
// Combinational round-robin arbiter: the search starts one past last_grant and wraps modulo NUM_REQ.
module apb_rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    logic [IDX_W-1:0] cand_idx [NUM_REQ];

    // cand_idx[gi] is the requester at priority rank gi (rank 0 = highest).
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            logic [IDX_W:0] sum;
            assign sum = {1'b0, last_grant} + (IDX_W+1)'(gi + 1);
            assign cand_idx[gi] = (sum >= (IDX_W+1)'(NUM_REQ)) ?
                                  IDX_W'(sum - (IDX_W+1)'(NUM_REQ)) : IDX_W'(sum);
        end
    endgenerate

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        if (enable) begin
            // Walk from lowest to highest priority so the highest-priority hit is the last write.
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (req[cand_idx[i]]) begin
                    grant_idx   = cand_idx[i];
                    grant_valid = 1'b1;
                end
            end
            if (grant_valid) begin
                grant = NUM_REQ'(1) << grant_idx;
            end
        end
    end

endmodule

// File: rtl/apb_rr_master.sv
// Round-robin APB master sharing one completer between NUM_REQ requesters.
// Optional ACCESS-phase watchdog is built when APB_TIMEOUT_EN is defined.
module apb_rr_master
    import apb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int DATA_WIDTH     = APB_DATA_WIDTH,
    parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic            PCLK,
    input  logic            PRESETn,
    apb_rr_master_if.master bus
);

    localparam int IDX_W = $clog2(NUM_REQ);

    generate
        if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
            $error("apb_rr_master: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
        end
    endgenerate

    apb_state_e            state_reg;
    logic [IDX_W-1:0]      last_grant_reg;
    logic                  psel_reg;
    logic                  penable_reg;
    logic                  pwrite_reg;
    logic [ADDR_WIDTH-1:0] paddr_reg;
    logic [DATA_WIDTH-1:0] pwdata_reg;
    logic [NUM_REQ-1:0]    rsp_valid_reg;
    logic [DATA_WIDTH-1:0] rsp_rdata_reg;
    logic                  rsp_err_reg;

    logic                  accept_pt;
    logic                  complete;
    logic                  timeout_hit;
    logic [NUM_REQ-1:0]    grant;
    logic [IDX_W-1:0]      grant_idx;
    logic                  grant_valid;
    logic                  win_write;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_wdata;

    // A timeout completes the transfer but is not an accept point; arbitration resumes from IDLE.
    assign accept_pt = (state_reg == IDLE) || ((state_reg == ACCESS) && bus.PREADY);
    assign complete  = (state_reg == ACCESS) && (bus.PREADY || timeout_hit);

    apb_rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .req        (bus.req_valid),
        .last_grant (last_grant_reg),
        .enable     (accept_pt),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid)
    );

    assign win_write = bus.req_write[grant_idx];
    assign win_addr  = bus.req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign win_wdata = bus.req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];

`ifdef APB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_reg;

    // Counts stalled ACCESS cycles; the TIMEOUT_CYCLES-th stalled cycle aborts unless PREADY rises.
    assign timeout_hit = (state_reg == ACCESS) && !bus.PREADY &&
                         (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            to_cnt_reg <= '0;
        end else if (state_reg == SETUP) begin
            to_cnt_reg <= '0;
        end else if ((state_reg == ACCESS) && !bus.PREADY) begin
            to_cnt_reg <= to_cnt_reg + TO_W'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_reg      <= IDLE;
            last_grant_reg <= IDX_W'(NUM_REQ - 1);
            psel_reg       <= 1'b0;
            penable_reg    <= 1'b0;
            pwrite_reg     <= 1'b0;
            paddr_reg      <= '0;
            pwdata_reg     <= '0;
            rsp_valid_reg  <= '0;
            rsp_rdata_reg  <= '0;
            rsp_err_reg    <= 1'b0;
        end else begin
            rsp_valid_reg <= '0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;

            if (complete) begin
                rsp_valid_reg <= NUM_REQ'(1) << last_grant_reg;
                rsp_rdata_reg <= (pwrite_reg || timeout_hit) ? '0 : bus.PRDATA;
                rsp_err_reg   <= timeout_hit;
            end

            if (grant_valid) begin
                // Accept: IDLE->SETUP or back-to-back ACCESS->SETUP with PSEL held high.
                state_reg      <= SETUP;
                last_grant_reg <= grant_idx;
                psel_reg       <= 1'b1;
                penable_reg    <= 1'b0;
                pwrite_reg     <= win_write;
                paddr_reg      <= win_addr;
                pwdata_reg     <= win_write ? win_wdata : '0;
            end else if (state_reg == SETUP) begin
                state_reg   <= ACCESS;
                penable_reg <= 1'b1;
            end else if (complete) begin
                state_reg   <= IDLE;
                psel_reg    <= 1'b0;
                penable_reg <= 1'b0;
                pwrite_reg  <= 1'b0;
                paddr_reg   <= '0;
                pwdata_reg  <= '0;
            end
        end
    end

    assign bus.req_ready = grant;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_rdata = rsp_rdata_reg;
    assign bus.rsp_err   = rsp_err_reg;
    assign bus.PSEL      = psel_reg;
    assign bus.PENABLE   = penable_reg;
    assign bus.PWRITE    = pwrite_reg;
    assign bus.PADDR     = paddr_reg;
    assign bus.PWDATA    = pwdata_reg;

endmodule

// File: tb/tb_apb_rr_master.sv
// Directed bench for apb_rr_master against a 32-word APB memory model with programmable wait states.
module tb_apb_rr_master;

    logic PCLK;
    logic PRESETn;

    apb_rr_master_if #(.NUM_REQ(2), .DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    apb_rr_master #(
        .NUM_REQ       (2),
        .DATA_WIDTH    (32),
        .ADDR_WIDTH    (32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .PCLK   (PCLK),
        .PRESETn(PRESETn),
        .bus    (bus)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Completer model: PREADY after wait_cfg stalled ACCESS cycles unless stall forces it low.
    logic [31:0] mem [32];
    int          wait_cfg;
    logic        stall;
    int          wcnt = 0;

    assign bus.PREADY = bus.PSEL && bus.PENABLE && !stall && (wcnt >= wait_cfg);
    assign bus.PRDATA = (bus.PSEL && !bus.PWRITE) ? mem[bus.PADDR[6:2]] : 32'h0;

    always @(posedge PCLK) begin
        if (bus.PSEL && bus.PENABLE && !bus.PREADY) wcnt <= wcnt + 1;
        else                                        wcnt <= 0;
        if (bus.PSEL && bus.PENABLE && bus.PREADY && bus.PWRITE)
            mem[bus.PADDR[6:2]] <= bus.PWDATA;
    end

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge PCLK);
        #1;
    endtask

    initial begin
        PRESETn       = 1'b0;
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        wait_cfg      = 0;
        stall         = 1'b0;

        // Reset state
        #2;
        chk("rst_psel", bus.PSEL, 1'b0);
        chk("rst_penable", bus.PENABLE, 1'b0);
        chk("rst_rsp_valid", bus.rsp_valid, 2'b00);
        chk("rst_paddr", bus.PADDR, 32'h0);
        tick; tick;
        PRESETn = 1'b1;
        tick;

        // Single write, 2 wait states
        wait_cfg = 2;
        bus.req_valid = 2'b01; bus.req_write = 2'b01;
        bus.req_addr[31:0] = 32'h0000_000C; bus.req_wdata[31:0] = 32'hDEAD_BEEF;
        #1;
        chk("wr_ready", bus.req_ready, 2'b01);
        tick;
        bus.req_valid = 2'b00;
        chk("wr_setup_psel", bus.PSEL, 1'b1);
        chk("wr_setup_penable", bus.PENABLE, 1'b0);
        chk("wr_setup_paddr", bus.PADDR, 32'h0000_000C);
        chk("wr_setup_pwrite", bus.PWRITE, 1'b1);
        chk("wr_setup_pwdata", bus.PWDATA, 32'hDEAD_BEEF);
        for (int c = 0; c < 3; c++) begin
            tick;
            chk("wr_access_penable", bus.PENABLE, 1'b1);
            chk("wr_access_pready", bus.PREADY, (c == 2) ? 1'b1 : 1'b0);
            chk("wr_access_rsp_valid", bus.rsp_valid, 2'b00);
        end
        tick;
        chk("wr_rsp_valid", bus.rsp_valid, 2'b01);
        chk("wr_rsp_err", bus.rsp_err, 1'b0);
        chk("wr_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("wr_psel_idle", bus.PSEL, 1'b0);
        chk("wr_mem3", mem[3], 32'hDEAD_BEEF);
        tick;
        chk("wr_rsp_valid_drop", bus.rsp_valid, 2'b00);

        // Zero-wait read by requester 1
        wait_cfg = 0;
        bus.req_valid = 2'b10; bus.req_write = 2'b00;
        bus.req_addr[63:32] = 32'h0000_000C; bus.req_wdata[63:32] = 32'h1234_5678;
        #1;
        chk("rd_ready", bus.req_ready, 2'b10);
        tick;
        bus.req_valid = 2'b00;
        chk("rd_setup_psel", bus.PSEL, 1'b1);
        chk("rd_setup_pwrite", bus.PWRITE, 1'b0);
        chk("rd_setup_pwdata", bus.PWDATA, 32'h0);
        chk("rd_setup_paddr", bus.PADDR, 32'h0000_000C);
        tick;
        chk("rd_access_pready", bus.PREADY, 1'b1);
        tick;
        chk("rd_rsp_valid", bus.rsp_valid, 2'b10);
        chk("rd_rsp_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
        chk("rd_rsp_err", bus.rsp_err, 1'b0);
        tick;
        chk("rd_rsp_valid_drop", bus.rsp_valid, 2'b00);
        chk("rd_rsp_rdata_drop", bus.rsp_rdata, 32'h0);

        // Contention: both requesters continuously valid, four transfers
        bus.req_valid = 2'b11; bus.req_write = 2'b01;
        bus.req_addr[31:0] = 32'h0000_0010; bus.req_wdata[31:0] = 32'h1111_1111;
        bus.req_addr[63:32] = 32'h0000_000C;
        #1;
        chk("rr_ready_first", bus.req_ready, 2'b01);
        tick;
        for (int k = 0; k < 4; k++) begin
            chk("rr_setup_psel", bus.PSEL, 1'b1);
            chk("rr_setup_penable", bus.PENABLE, 1'b0);
            chk("rr_setup_paddr", bus.PADDR, (k % 2 == 0) ? 32'h0000_0010 : 32'h0000_000C);
            if (k > 0) begin
                chk("rr_rsp_valid", bus.rsp_valid, (k % 2 == 1) ? 2'b01 : 2'b10);
                chk("rr_rsp_rdata", bus.rsp_rdata, (k % 2 == 1) ? 32'h0 : 32'hDEAD_BEEF);
            end
            tick;
            chk("rr_access_psel", bus.PSEL, 1'b1);
            chk("rr_access_penable", bus.PENABLE, 1'b1);
            if (k == 3) begin
                bus.req_valid = 2'b00;
                #1;
                chk("rr_ready_last", bus.req_ready, 2'b00);
            end else begin
                chk("rr_ready_next", bus.req_ready, (k % 2 == 0) ? 2'b10 : 2'b01);
            end
            tick;
        end
        chk("rr_rsp_valid_last", bus.rsp_valid, 2'b10);
        chk("rr_rsp_rdata_last", bus.rsp_rdata, 32'hDEAD_BEEF);
        chk("rr_psel_idle", bus.PSEL, 1'b0);
        chk("rr_mem4", mem[4], 32'h1111_1111);

        // Asynchronous reset in the middle of a stalled ACCESS
        stall = 1'b1;
        bus.req_valid = 2'b01; bus.req_write = 2'b00;
        #1;
        chk("ar_ready", bus.req_ready, 2'b01);
        tick;
        bus.req_valid = 2'b00;
        tick;
        chk("ar_access_penable", bus.PENABLE, 1'b1);
        tick;
        #3;
        PRESETn = 1'b0;
        #1;
        chk("ar_psel_async", bus.PSEL, 1'b0);
        chk("ar_penable_async", bus.PENABLE, 1'b0);
        chk("ar_rsp_valid_async", bus.rsp_valid, 2'b00);
        tick;
        chk("ar_rsp_valid_in_rst", bus.rsp_valid, 2'b00);
        stall = 1'b0;
        bus.req_valid = 2'b10; bus.req_addr[63:32] = 32'h0000_0010;
        #2;
        PRESETn = 1'b1;
        #1;
        chk("ar_ready_req1", bus.req_ready, 2'b10);
        tick;
        bus.req_valid = 2'b00;
        chk("ar_setup_psel", bus.PSEL, 1'b1);
        chk("ar_setup_paddr", bus.PADDR, 32'h0000_0010);
        chk("ar_no_stale_rsp", bus.rsp_valid, 2'b00);
        tick;
        tick;
        chk("ar_rsp_valid", bus.rsp_valid, 2'b10);
        chk("ar_rsp_rdata", bus.rsp_rdata, 32'h1111_1111);
        tick;

        // Address/data/control stable while PREADY goes 0,0,1 and req_addr changes
        wait_cfg = 2;
        bus.req_valid = 2'b01; bus.req_write = 2'b01;
        bus.req_addr[31:0] = 32'h0000_0014; bus.req_wdata[31:0] = 32'hA5A5_A5A5;
        #1;
        chk("st_ready", bus.req_ready, 2'b01);
        tick;
        bus.req_valid = 2'b00; bus.req_write = 2'b00;
        bus.req_addr[31:0] = 32'h0000_001C; bus.req_wdata[31:0] = 32'h5A5A_5A5A;
        for (int c = 0; c < 3; c++) begin
            tick;
            chk("st_paddr", bus.PADDR, 32'h0000_0014);
            chk("st_pwdata", bus.PWDATA, 32'hA5A5_A5A5);
            chk("st_pwrite", bus.PWRITE, 1'b1);
            chk("st_pready", bus.PREADY, (c == 2) ? 1'b1 : 1'b0);
        end
        tick;
        chk("st_rsp_valid", bus.rsp_valid, 2'b01);
        chk("st_mem5", mem[5], 32'hA5A5_A5A5);

        // Read back through requester 1
        wait_cfg = 0;
        bus.req_valid = 2'b10; bus.req_addr[63:32] = 32'h0000_0014;
        #1;
        chk("rb_ready", bus.req_ready, 2'b10);
        tick;
        bus.req_valid = 2'b00;
        tick;
        tick;
        chk("rb_rsp_valid", bus.rsp_valid, 2'b10);
        chk("rb_rsp_rdata", bus.rsp_rdata, 32'hA5A5_A5A5);
        tick;

`ifdef APB_TIMEOUT_EN
        // Watchdog abort after four stalled ACCESS cycles, then a normal transfer
        stall = 1'b1;
        bus.req_valid = 2'b01; bus.req_write = 2'b00; bus.req_addr[31:0] = 32'h0000_0014;
        #1;
        chk("to_ready", bus.req_ready, 2'b01);
        tick;
        bus.req_valid = 2'b00;
        for (int c = 0; c < 4; c++) begin
            tick;
            chk("to_access_penable", bus.PENABLE, 1'b1);
        end
        tick;
        chk("to_rsp_valid", bus.rsp_valid, 2'b01);
        chk("to_rsp_err", bus.rsp_err, 1'b1);
        chk("to_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("to_psel_drop", bus.PSEL, 1'b0);
        stall = 1'b0;
        bus.req_valid = 2'b01;
        #1;
        chk("to_next_ready", bus.req_ready, 2'b01);
        tick;
        bus.req_valid = 2'b00;
        tick;
        tick;
        chk("to_next_rsp_valid", bus.rsp_valid, 2'b01);
        chk("to_next_rsp_err", bus.rsp_err, 1'b0);
        chk("to_next_rsp_rdata", bus.rsp_rdata, 32'hA5A5_A5A5);
        tick;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
